// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator constants, converter defaults and converter FSM states.
package calc_pkg;
    localparam int DEF_BIN_W = 14;
    localparam int DEF_DIGITS = 4;
    localparam int unsigned BCD_MAX = 9999;
    localparam logic [3:0] BLANK_DIGIT = 4'hF;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bcd_seq_convert.sv
// bcd_seq_convert: sequential shift/add-3 binary-to-BCD converter with overflow saturation.
// Define BCD_BLANK_EN to blank leading zero digits with BLANK_DIGIT.
module bcd_seq_convert
    import calc_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       num4,
    output logic [3:0]       num3,
    output logic [3:0]       num2,
    output logic [3:0]       num1
);
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0] sr_q, sr_d;
    logic [DW-1:0]    bcd_q, bcd_d;
    logic [DW-1:0]    num_q, num_d;
    logic             ovf_cap_q, ovf_cap_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [DW-1:0]    adj, raw, shown;
`ifdef BCD_BLANK_EN
    logic             lead;
`endif

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_adj
            bcd_digit_adj u_adj (.d(bcd_q[4*i +: 4]), .q(adj[4*i +: 4]));
        end
    endgenerate

    // Saturation overrides the scratch digits; a saturated 9999 is never blanked.
    always_comb begin
        raw = ovf_cap_q ? {DIGITS{4'd9}} : bcd_q;
        shown = raw;
`ifdef BCD_BLANK_EN
        lead = !ovf_cap_q;
        for (int j = DIGITS - 1; j > 0; j--) begin
            lead = lead && (raw[4*j +: 4] == 4'd0);
            shown[4*j +: 4] = lead ? BLANK_DIGIT : raw[4*j +: 4];
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        bcd_d     = bcd_q;
        num_d     = num_q;
        ovf_cap_d = ovf_cap_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d      = bin;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    ovf_cap_d = 32'(bin) > BCD_MAX;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, sr_d} = {adj[DW-2:0], sr_q, 1'b0};
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(BIN_W - 1)) ? DONE : SHIFT;
            end
            DONE: begin
                num_d   = shown;
                ovf_d   = ovf_cap_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            bcd_q     <= '0;
            num_q     <= '0;
            ovf_cap_q <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            bcd_q     <= bcd_d;
            num_q     <= num_d;
            ovf_cap_q <= ovf_cap_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign {num4, num3, num2, num1} = num_q;
endmodule

// File: tb/tb_bcd_seq_convert.sv
// tb_bcd_seq_convert: directed and random checks of bcd_seq_convert against a decimal model.
// Define BCD_BLANK_EN for both bench and RTL to check leading-zero blanking.
module tb_bcd_seq_convert;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        busy, done, ovf;
    logic [3:0]  num4, num3, num2, num1;
    int          n_checks = 0;
    int          n_fail = 0;

    bcd_seq_convert dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .ovf(ovf),
        .num4(num4), .num3(num3), .num2(num2), .num1(num1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] got();
        return {num4, num3, num2, num1};
    endfunction

    // Decimal digits by plain division, saturated at 9999.
    function automatic logic [15:0] ref_digits(input int v);
        int s;
        logic [15:0] r;
        s = (v > 9999) ? 9999 : v;
        r = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
`ifdef BCD_BLANK_EN
        if (v <= 9999) begin
            if (s < 1000) r[15:12] = 4'hF;
            if (s < 100) r[11:8] = 4'hF;
            if (s < 10) r[7:4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic run_conv(input int v);
        int lat, bc;
        bin = 14'(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        bin = 14'($urandom);
        lat = 0;
        bc = 0;
        while (!done && lat < 40) begin
            bc += int'(busy);
            tick();
            lat++;
        end
        check($sformatf("latency(%0d)", v), lat, 15);
        check($sformatf("busy_cycles(%0d)", v), bc, 15);
        check($sformatf("busy_in_done(%0d)", v), busy, 0);
        check($sformatf("digits(%0d)", v), got(), ref_digits(v));
        check($sformatf("ovf(%0d)", v), ovf, v > 9999);
        tick();
        check($sformatf("done_pulse(%0d)", v), done, 0);
    endtask

    initial begin
        int prev, ndone, v;
        start = 1'b1;
        bin = 14'd1234;
        tick();
        tick();
        start = 1'b0;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_digits", got(), 0);
        tick();
        check("rst_idle", busy, 0);

        run_conv(1234);
        run_conv(0);
        run_conv(9999);
        run_conv(10000);
        run_conv(16383);
        run_conv(7);
        run_conv(305);
        for (int k = 0; k < 8; k++) run_conv(int'($urandom_range(0, 16383)));

        // start mid-conversion must be ignored
        bin = 14'd2468;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        bin = 14'd1357;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                ndone++;
                check("mid_start_digits", got(), ref_digits(2468));
            end
            tick();
        end
        check("mid_start_done_count", ndone, 1);
        check("mid_start_idle", busy, 0);

        // start held high: accepted every 16 cycles
        prev = -1;
        ndone = 0;
        bin = 14'd777;
        start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (done) begin
                if (prev >= 0) check("held_spacing", c - prev, 16);
                check("held_digits", got(), ref_digits(777));
                prev = c;
                ndone++;
            end
        end
        start = 1'b0;
        check("held_done_count", ndone, 4);
        repeat (30) tick();
        check("held_drain_idle", busy, 0);

        // reset during the shift phase aborts the conversion
        run_conv(5678);
        bin = 14'd4321;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("pre_abort_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ovf", ovf, 0);
        check("abort_digits", got(), 0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            ndone += int'(done) + int'(busy);
            tick();
        end
        check("abort_quiet", ndone, 0);
        run_conv(42);

        for (int k = 0; k < 4; k++) begin
            v = int'($urandom_range(0, 99));
            run_conv(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
